inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction fetch and issue stage, the producer side of the control-unit interface.
- Holds the word-addressed PC, fetches 32-bit instructions from instruction memory over a req/ack handshake, and splits each instruction into i_code, ri, rk and extended immediates.
- Presents the instruction to the control unit and datapath under a valid/ready handshake.
- Takes the control unit's pc_sel/ext_sel back to form the next PC.

Parameters:
ADDR_W, 10, PC and instruction-memory word-address width
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
run  in  1  fetch enable; level-sensitive
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch word address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
inst_valid  out  1  decoded instruction fields valid
inst_ready  in  1  downstream accepts instruction
i_code  out  6  instruction[31:26]
ri  out  5  instruction[25:21]
rk  out  5  instruction[20:16]
imm16_ext  out  32  sign-extended instruction[15:0]
imm26_ext  out  32  sign-extended instruction[25:0]
pc_sel  in  1  1 = take PC-relative redirect
ext_sel  in  1  1 = redirect offset is imm26_ext, else imm16_ext
pc  out  ADDR_W  current PC
halted  out  1  sticky, illegal opcode encountered
illegal  out  1  sticky, same event as halted (separate for debug/status)

Behaviour:
- Reset (rst=1 at the clock edge): state=S_IDLE, pc=RESET_PC, instruction register=0, halted=0, illegal=0.
  - All outputs derived from the registers: imem_req=0, inst_valid=0, i_code/ri/rk=0, imm*_ext=0.
  - Reset overrides every other event, including an outstanding fetch. An imem_ack arriving after reset is ignored.
- imem_req and inst_valid are decoded from the registered state only; no combinational path from inputs.
- States:
  - S_IDLE: imem_req=0, inst_valid=0. run=1 -> S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc, held stable until ack. On imem_ack=1, latch imem_rdata into the instruction register.
    - If latched i_code > 6'b000101: -> S_HALT.
    - Otherwise: -> S_ISSUE.
    - run falling while in S_REQ does not cancel the request.
  - S_ISSUE: inst_valid=1; fields are stable while waiting. When inst_ready=1 (transfer cycle), sample pc_sel/ext_sel in that same cycle:
    - pc_sel=0: pc <= pc+1.
    - pc_sel=1: pc <= pc+1+offset, where offset = ext_sel ? imm26_ext : imm16_ext.
    - The sum is truncated to ADDR_W bits, so wrap-around is modulo 2^ADDR_W.
    - Next state: S_REQ if run=1, else S_IDLE.
    - The instruction is always issued even if run dropped before or during S_ISSUE.
  - S_HALT: imem_req=0, inst_valid=0, halted=1, illegal=1, pc holds the illegal instruction's address. Exited only by rst.
- pc_sel/ext_sel are ignored outside the S_ISSUE transfer cycle.
- Latency:
  - imem_ack in the first S_REQ cycle -> inst_valid in the next cycle.
  - Minimum issue interval is 2 cycles (REQ, ISSUE).
- Opcode 6'b000000 (NOP) is issued normally and advances pc by 1.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds outputs issue_cnt (32) and redirect_cnt (32), both reset to 0 by rst.
  - issue_cnt increments on each S_ISSUE transfer.
  - redirect_cnt increments on each transfer with pc_sel=1.
  - Both wrap at 2^32 and freeze in S_HALT.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, run=1, memory returns 0x04000005 at addr 0 with ack in the same cycle as req -> inst_valid next cycle; i_code=000001, ri=0, rk=0, imm16_ext=5; with inst_ready=1 and pc_sel=0 -> pc=1, imem_req=1 on addr 1.
- BEQ taken: instruction 0x1000FFFC at pc=8, inst_ready=1, pc_sel=1, ext_sel=0 -> pc=8+1-4=5.
- JUMP wrap: ADDR_W=10, pc=1020, imm26_ext=+10, pc_sel=1, ext_sel=1 -> pc=(1031 mod 1024)=7.
- Backpressure: inst_ready=0 for 5 cycles -> inst_valid held, fields stable, imem_req=0, pc unchanged; pc advances only on the ready cycle.
- Illegal opcode 6'b111111 fetched at pc=3 -> no inst_valid, halted=illegal=1, pc=3, imem_req stays 0 for 20 cycles with run=1; rst -> halted=0, pc=RESET_PC.
- Mid-operation events:
  - rst during S_REQ with ack 2 cycles later -> ack ignored, state S_IDLE, inst_valid=0.
  - run dropped during S_REQ -> the instruction is still issued once, then S_IDLE with imem_req=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch and issue stage.
//
// Holds the word-addressed PC, fetches 32-bit instructions over a req/ack
// handshake, splits them into i_code/ri/rk and sign-extended immediates, and
// presents them to the control unit under a valid/ready handshake. The
// control unit's pc_sel/ext_sel, sampled on the transfer cycle, form the
// next PC. An opcode above 6'b000101 halts the unit until reset.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   run                      level-sensitive fetch enable
//   imem_req/addr/ack/rdata  instruction memory handshake
//   inst_valid/inst_ready    issue handshake
//   i_code, ri, rk           instruction[31:26], [25:21], [20:16]
//   imm16_ext, imm26_ext     sign-extended instruction[15:0] / [25:0]
//   pc_sel, ext_sel          redirect control from the control unit
//   pc                       current PC
//   halted, illegal          sticky illegal-opcode status
//   issue_cnt, redirect_cnt  only when IFU_PERF_CNT_EN is defined
//
// Optional feature: define IFU_PERF_CNT_EN to add the performance counters.
// ADDR_W is assumed to be at most 32.

module inst_fetch_unit #(
    parameter int unsigned        ADDR_W   = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [5:0]        i_code,
    output logic [4:0]        ri,
    output logic [4:0]        rk,
    output logic [31:0]       imm16_ext,
    output logic [31:0]       imm26_ext,
    input  logic              pc_sel,
    input  logic              ext_sel,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]       issue_cnt,
    output logic [31:0]       redirect_cnt,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [1:0] {StIdle, StReq, StIssue, StHalt} state_e;

    localparam logic [5:0] MaxLegalOp = 6'b000101;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              transfer;
    logic [31:0]       offset;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign offset = ext_sel ? imm26_ext : imm16_ext;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        transfer = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StReq;
            end
            StReq: begin
                // Once requested, the fetch completes regardless of run.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = (imem_rdata[31:26] > MaxLegalOp) ? StHalt : StIssue;
                end
            end
            StIssue: begin
                if (inst_ready) begin
                    transfer = 1'b1;
                    // Sum formed at 32 bits, truncated: wraps modulo 2^ADDR_W.
                    if (pc_sel) pc_d = ADDR_W'(32'(pc_q) + 32'd1 + offset);
                    else        pc_d = pc_q + ADDR_W'(1);
                    state_d = run ? StReq : StIdle;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StReq:   imem_req   = 1'b1;
            StIssue: inst_valid = 1'b1;
            StHalt:  halted     = 1'b1;
        endcase
    end

    assign illegal   = halted;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign i_code    = ir_q[31:26];
    assign ri        = ir_q[25:21];
    assign rk        = ir_q[20:16];
    assign imm16_ext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm26_ext = {{6{ir_q[25]}}, ir_q[25:0]};

`ifdef IFU_PERF_CNT_EN
    logic [31:0] issue_cnt_q, redirect_cnt_q;

    // Transfers never happen in StHalt, so the counters freeze there.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else if (transfer) begin
            issue_cnt_q <= issue_cnt_q + 32'd1;
            if (pc_sel) redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign issue_cnt    = issue_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`else
    logic unused_transfer;
    assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit (ADDR_W=10, RESET_PC=0).
module tb_inst_fetch_unit;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [5:0]        i_code;
    logic [4:0]        ri;
    logic [4:0]        rk;
    logic [31:0]       imm16_ext;
    logic [31:0]       imm26_ext;
    logic              pc_sel = 1'b0;
    logic              ext_sel = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              illegal;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]       issue_cnt;
    logic [31:0]       redirect_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .i_code     (i_code),
        .ri         (ri),
        .rk         (rk),
        .imm16_ext  (imm16_ext),
        .imm26_ext  (imm26_ext),
        .pc_sel     (pc_sel),
        .ext_sel    (ext_sel),
`ifdef IFU_PERF_CNT_EN
        .issue_cnt    (issue_cnt),
        .redirect_cnt (redirect_cnt),
`endif
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From StReq: ack the given word, then transfer with the given redirect.
    task automatic fetch_issue(input logic [31:0] word, input logic sel, input logic ext);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        pc_sel     = sel;
        ext_sel    = ext;
        tick();
        inst_ready = 1'b0;
        pc_sel     = 1'b0;
        ext_sel    = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_icode", 32'(i_code), 32'd0);
        check("rst_imm16", imm16_ext, 32'd0);
        check("rst_imm26", imm26_ext, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // First fetch, ack in the same cycle as req
        run = 1'b1;
        tick();
        check("req0_req", 32'(imem_req), 32'd1);
        check("req0_addr", 32'(imem_addr), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0400_0005;
        tick();
        imem_ack = 1'b0;
        check("iss0_valid", 32'(inst_valid), 32'd1);
        check("iss0_icode", 32'(i_code), 32'd1);
        check("iss0_ri", 32'(ri), 32'd0);
        check("iss0_rk", 32'(rk), 32'd0);
        check("iss0_imm16", imm16_ext, 32'd5);

        // Backpressure; pc_sel held high must be ignored while not transferring
        pc_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(inst_valid), 32'd1);
            check("bp_imm16", imm16_ext, 32'd5);
            check("bp_req", 32'(imem_req), 32'd0);
            check("bp_pc", 32'(pc), 32'd0);
        end
        pc_sel     = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("adv_pc", 32'(pc), 32'd1);
        check("adv_req", 32'(imem_req), 32'd1);
        check("adv_addr", 32'(imem_addr), 32'd1);
        check("adv_valid", 32'(inst_valid), 32'd0);

        // NOPs from pc=1 to pc=8
        for (int i = 0; i < 7; i++) fetch_issue(32'h0000_0000, 1'b0, 1'b0);
        check("nop_pc", 32'(pc), 32'd8);

        // BEQ taken, imm16=-4: 8+1-4 = 5
        imem_ack   = 1'b1;
        imem_rdata = 32'h1000_FFFC;
        tick();
        imem_ack = 1'b0;
        check("beq_icode", 32'(i_code), 32'd4);
        check("beq_imm16", imm16_ext, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        pc_sel     = 1'b1;
        tick();
        inst_ready = 1'b0;
        pc_sel     = 1'b0;
        check("beq_pc", 32'(pc), 32'd5);

        // Forward branch to 1020: 5+1+1014
        fetch_issue(32'h1000_03F6, 1'b1, 1'b0);
        check("fwd_pc", 32'(pc), 32'd1020);

        // JUMP wrap: 1020+1+10 = 1031 mod 1024 = 7
        imem_ack   = 1'b1;
        imem_rdata = 32'h1400_000A;
        tick();
        imem_ack = 1'b0;
        check("jmp_imm26", imm26_ext, 32'd10);
        inst_ready = 1'b1;
        pc_sel     = 1'b1;
        ext_sel    = 1'b1;
        tick();
        inst_ready = 1'b0;
        pc_sel     = 1'b0;
        ext_sel    = 1'b0;
        check("jmp_pc", 32'(pc), 32'd7);

        // Field split and sign extension: op=3 ri=5 rk=10 imm=0x8000
        imem_ack   = 1'b1;
        imem_rdata = 32'h0CAA_8000;
        tick();
        imem_ack = 1'b0;
        check("fld_icode", 32'(i_code), 32'd3);
        check("fld_ri", 32'(ri), 32'd5);
        check("fld_rk", 32'(rk), 32'd10);
        check("fld_imm16", imm16_ext, 32'hFFFF_8000);
        check("fld_imm26", imm26_ext, 32'h00AA_8000);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("fld_pc", 32'(pc), 32'd8);

        // imm26 = -1 with ext_sel=1: pc+1-1 = pc
        fetch_issue(32'h17FF_FFFF, 1'b1, 1'b1);
        check("neg26_pc", 32'(pc), 32'd8);

        // run dropped during StReq: still issued once, then idle
        run = 1'b0;
        tick();
        check("rdrop_req", 32'(imem_req), 32'd1);
        check("rdrop_addr", 32'(imem_addr), 32'd8);
        fetch_issue(32'h0000_0000, 1'b0, 1'b0);
        check("rdrop_pc", 32'(pc), 32'd9);
        check("rdrop_idle_req", 32'(imem_req), 32'd0);
        check("rdrop_idle_valid", 32'(inst_valid), 32'd0);
        tick();
        check("rdrop_idle_req2", 32'(imem_req), 32'd0);

        // Illegal opcode at pc=3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) fetch_issue(32'h0000_0000, 1'b0, 1'b0);
        check("ill_pre_pc", 32'(pc), 32'd3);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFC00_0000;
        tick();
        imem_ack = 1'b0;
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_illegal", 32'(illegal), 32'd1);
        check("ill_valid", 32'(inst_valid), 32'd0);
        check("ill_pc", 32'(pc), 32'd3);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_req", 32'(imem_req), 32'd0);
        end
        check("halt_pc", 32'(pc), 32'd3);
        check("halt_valid", 32'(inst_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b0;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_illegal", 32'(illegal), 32'd0);
        check("unhalt_pc", 32'(pc), 32'd0);

        // rst during StReq, ack arrives 2 cycles later and must be ignored
        run = 1'b1;
        tick();
        check("rreq_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        run = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0400_0005;
        tick();
        imem_ack = 1'b0;
        check("rreq_valid", 32'(inst_valid), 32'd0);
        check("rreq_reqlow", 32'(imem_req), 32'd0);
        check("rreq_icode", 32'(i_code), 32'd0);
        tick();
        check("rreq_valid2", 32'(inst_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
